k12a_skip_unit: RTL

//   Parametrised skip/predicate unit; successor to the single-bit skip flag.

---
 rtl/k12a_skip_unit_pkg.sv | 18 +
 rtl/k12a_skip_unit_if.sv | 36 +++
 rtl/k12a_skip_flag_bank.sv | 31 +++
 rtl/k12a_skip_unit.sv | 68 ++++++
 4 files changed

// File: rtl/k12a_skip_unit_pkg.sv
// Shared types for the k12a skip/predicate unit.
// Skip condition encodings plus flag index width helper.
package k12a_skip_unit_pkg;

  typedef enum logic [2:0] {
    SKIP_SEL_0                  = 3'd0,
    SKIP_SEL_CONDITION          = 3'd1,
    SKIP_SEL_CONDITION_INVERTED = 3'd2,
    SKIP_SEL_FLAG               = 3'd3,
    SKIP_SEL_FLAG_INVERTED      = 3'd4,
    SKIP_SEL_1                  = 3'd5
  } skip_sel_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/k12a_skip_unit_if.sv
// Control-unit <-> skip unit bundle.
// master = control unit, slave = skip unit.
interface k12a_skip_unit_if
  import k12a_skip_unit_pkg::*;
#(
  parameter int COUNT_WIDTH = 2,
  parameter int NUM_FLAGS   = 4
);
  localparam int FLAG_IDX_W = idx_width(NUM_FLAGS);

  logic                   alu_condition;
  skip_sel_t              skip_sel;
  logic                   skip_store;
  logic [COUNT_WIDTH-1:0] skip_len;
  logic [FLAG_IDX_W-1:0]  flag_idx;
  logic                   flag_store;
  logic                   instr_retire;
  logic                   skip;
  logic [COUNT_WIDTH-1:0] skip_count;
  logic [NUM_FLAGS-1:0]   flags;

  modport master (
    output alu_condition, skip_sel, skip_store,
    output skip_len, flag_idx, flag_store,
    output instr_retire,
    input  skip, skip_count, flags
  );

  modport slave (
    input  alu_condition, skip_sel, skip_store,
    input  skip_len, flag_idx, flag_store,
    input  instr_retire,
    output skip, skip_count, flags
  );

endinterface

// File: rtl/k12a_skip_flag_bank.sv
// Stored predicate flags with indexed write and
// range-checked read; out-of-range reads give 0.
module k12a_skip_flag_bank
  import k12a_skip_unit_pkg::*;
#(
  parameter  int NUM_FLAGS  = 4,
  localparam int FLAG_IDX_W = idx_width(NUM_FLAGS)
) (
  input  logic                  cpu_clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [FLAG_IDX_W-1:0] idx,
  input  logic                  wr_data,
  output logic                  rd_data,
  output logic [NUM_FLAGS-1:0]  flags
);

  logic in_range;

  assign in_range = (32'(idx) < 32'(NUM_FLAGS));
  assign rd_data  = in_range ? flags[idx] : 1'b0;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else if (wr_en && in_range) begin
      flags[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/k12a_skip_unit.sv
// Skip/predicate unit: down-counter suppressing the
// next N retiring instructions, plus a flag bank.
module k12a_skip_unit
  import k12a_skip_unit_pkg::*;
#(
  parameter int COUNT_WIDTH = 2,
  parameter int NUM_FLAGS   = 4
) (
  input logic              cpu_clock,
  input logic              reset_n,
  k12a_skip_unit_if.slave  bus
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   skip_act;
  logic                   flag_rd;
  logic                   cond_bit;
  logic                   flag_we;

  assign skip_act       = (count_q != '0);
  assign bus.skip       = skip_act;
  assign bus.skip_count = count_q;

  // Skipped instructions have no side effects.
  assign flag_we = bus.flag_store & ~skip_act;

  k12a_skip_flag_bank #(
    .NUM_FLAGS (NUM_FLAGS)
  ) u_flag_bank (
    .cpu_clock (cpu_clock),
    .reset_n   (reset_n),
    .wr_en     (flag_we),
    .idx       (bus.flag_idx),
    .wr_data   (bus.alu_condition),
    .rd_data   (flag_rd),
    .flags     (bus.flags)
  );

  always_comb begin
    cond_bit = 1'b0;
    case (bus.skip_sel)
      SKIP_SEL_CONDITION:          cond_bit = bus.alu_condition;
      SKIP_SEL_CONDITION_INVERTED: cond_bit = ~bus.alu_condition;
      SKIP_SEL_FLAG:               cond_bit = flag_rd;
      SKIP_SEL_FLAG_INVERTED:      cond_bit = ~flag_rd;
      SKIP_SEL_1:                  cond_bit = 1'b1;
      default:                     cond_bit = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      skip_act && bus.instr_retire:
        count_d = count_q - COUNT_WIDTH'(1);
      !skip_act && bus.skip_store:
        count_d = cond_bit ? bus.skip_len : '0;
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule
